// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: board-control front end for the tunable clock divider.
//   Synchronizes and debounces the raw switches/button and drives the
//   divider's devide/enable inputs in free-run or single-step mode.
//   clkIn    - system clock
//   rst_n    - asynchronous reset, active low
//   swRun    - raw switch, 1 = free run, 0 = step mode
//   btnStep  - raw push button, 1 = pressed
//   swDevide - raw divide-select switches
//   devide   - registered divide select to the divider
//   enable   - registered enable to the divider
//   stepBusy - high while a single step is in progress
module sm_clk_ctrl_db #(
  parameter int W      = 1,
  parameter int DB_CNT = 16'hFFFF
) (
  input  logic         clkIn,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);
  logic [W-1:0] s1_q, s1_d, s2_q, s2_d, stable_q, stable_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         mis, hit;
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    mis      = s2_q != stable_q;
    hit      = cnt_q == 16'(DB_CNT - 1);
    cnt_d    = (!mis || hit) ? '0 : cnt_q + 16'd1;
    stable_d = (mis && hit) ? s2_q : stable_q;
  end
  always_ff @(posedge clkIn or negedge rst_n)
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  assign stable = stable_q;
endmodule

module sm_clk_ctrl #(
  parameter int SHIFT  = 16,
  parameter int DB_CNT = 16'hFFFF
) (
  input  logic       clkIn,
  input  logic       rst_n,
  input  logic       swRun,
  input  logic       btnStep,
  input  logic [3:0] swDevide,
  output logic [3:0] devide,
  output logic       enable,
  output logic       stepBusy
);
  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;
  state_t      state_q, state_d;
  logic        run_db, step_db, press;
  logic [3:0]  dev_db, devide_q, devide_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  sh;
  logic        enable_q, enable_d, busy_q, busy_d, step_prev_q, step_prev_d;
  sm_clk_ctrl_db #(.W(1), .DB_CNT(DB_CNT)) u_run (.clkIn(clkIn), .rst_n(rst_n), .raw(swRun), .stable(run_db));
  sm_clk_ctrl_db #(.W(1), .DB_CNT(DB_CNT)) u_stp (.clkIn(clkIn), .rst_n(rst_n), .raw(btnStep), .stable(step_db));
  sm_clk_ctrl_db #(.W(4), .DB_CNT(DB_CNT)) u_dev (.clkIn(clkIn), .rst_n(rst_n), .raw(swDevide), .stable(dev_db));
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press       = step_db & ~step_prev_q;
    // all-ones shifted down leaves 2^(SHIFT+devide+1)-1 without a 33-bit intermediate
    sh          = 6'(31 - SHIFT) - {2'b00, devide_q};
    case (state_q)
      IDLE:
        if (run_db) state_d = RUN;
        else if (press) begin
          state_d = STEP;
          cnt_d   = 32'hFFFF_FFFF >> sh;
        end
      RUN:
        if (!run_db) state_d = IDLE;
      STEP: begin
        cnt_d = (cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1;
        if (cnt_q == 32'd0) state_d = run_db ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // divide select frozen during a step so the step length stays consistent
    devide_d    = (state_q == STEP) ? devide_q : dev_db;
    enable_d    = state_d != IDLE;
    busy_d      = state_d == STEP;
    step_prev_d = step_db;
  end
  always_ff @(posedge clkIn or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      devide_q    <= '0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      devide_q    <= devide_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      step_prev_q <= step_prev_d;
    end
  assign devide   = devide_q;
  assign enable   = enable_q;
  assign stepBusy = busy_q;
endmodule

// File: tb/tb_sm_clk_ctrl.sv
// tb_sm_clk_ctrl: randomized and directed bench for sm_clk_ctrl against a cycle reference model.
module tb_sm_clk_ctrl;
  localparam int SHIFT = 1;
  localparam int DB    = 4;
  logic       clkIn = 1'b0, rst_n = 1'b1, swRun = 1'b1, btnStep = 1'b0;
  logic [3:0] swDevide = 4'd0;
  logic [3:0] devide;
  logic       enable, stepBusy;
  int tests = 0, fails = 0;
  int m_s1[3], m_s2[3], m_stab[3], m_run[3];
  int m_mode, m_rem, m_dev, m_prev;
  sm_clk_ctrl #(.SHIFT(SHIFT), .DB_CNT(DB)) dut (
    .clkIn(clkIn), .rst_n(rst_n), .swRun(swRun), .btnStep(btnStep),
    .swDevide(swDevide), .devide(devide), .enable(enable), .stepBusy(stepBusy));
  always #5 clkIn = ~clkIn;
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int f = 0; f < 3; f++) begin
      m_s1[f] = 0; m_s2[f] = 0; m_stab[f] = 0; m_run[f] = 0;
    end
    m_mode = 0; m_rem = 0; m_dev = 0; m_prev = 0;
  endtask
  // mode: 0 idle, 1 free run, 2 single step; m_rem = step cycles still to go
  task automatic model_edge();
    int raw[3];
    int p_stab[3];
    int p_mode, p_dev, press;
    raw    = '{int'(swRun), int'(btnStep), int'(swDevide)};
    p_stab = m_stab;
    p_mode = m_mode;
    p_dev  = m_dev;
    press  = (p_stab[1] == 1 && m_prev == 0) ? 1 : 0;
    for (int f = 0; f < 3; f++) begin
      if (m_s2[f] != m_stab[f]) begin
        m_run[f]++;
        if (m_run[f] == DB) begin
          m_stab[f] = m_s2[f];
          m_run[f]  = 0;
        end
      end else m_run[f] = 0;
    end
    m_s2   = m_s1;
    m_s1   = raw;
    m_prev = p_stab[1];
    if (p_mode != 2) m_dev = p_stab[2];
    case (p_mode)
      0: if (p_stab[0] != 0) m_mode = 1;
         else if (press != 0) begin
           m_mode = 2;
           m_rem  = 1 << (SHIFT + p_dev + 1);
         end
      1: if (p_stab[0] == 0) m_mode = 0;
      default: begin
        m_rem--;
        if (m_rem == 0) m_mode = (p_stab[0] != 0) ? 1 : 0;
      end
    endcase
  endtask
  task automatic check_outs();
    chk("devide", int'(devide), m_dev);
    chk("enable", int'(enable), (m_mode != 0) ? 1 : 0);
    chk("stepBusy", int'(stepBusy), (m_mode == 2) ? 1 : 0);
  endtask
  task automatic cyc();
    @(posedge clkIn);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check_outs();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_devide", int'(devide), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_busy", int'(stepBusy), 0);
  endtask
  initial begin
    int n, saw, ce, cb;
    model_reset();
    #1;
    do_reset();
    swRun = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    // free-run entry and exit latency
    swRun = 1'b1;
    n = 0;
    while (enable !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("run_rise_lat", n, 7);
    repeat (5) cyc();
    chk("run_hold", int'(enable), 1);
    swRun = 1'b0;
    n = 0;
    while (enable !== 1'b0 && n < 20) begin cyc(); n++; end
    chk("run_fall_lat", n, 7);
    // short glitch on the button
    swDevide = 4'd3;
    repeat (10) cyc();
    saw = 0;
    btnStep = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) btnStep = 1'b0;
      cyc();
      if (enable) saw = 1;
    end
    chk("glitch_no_step", saw, 0);
    // single step of 2^(1+3+1) cycles, held button gives one step
    ce = 0; cb = 0;
    btnStep = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) btnStep = 1'b0;
      cyc();
      ce += int'(enable); cb += int'(stepBusy);
    end
    chk("step_len", ce, 32);
    chk("step_busy_len", cb, 32);
    // divide select frozen mid-step
    ce = 0;
    btnStep = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) btnStep = 1'b0;
      if (i == 15) swDevide = 4'd0;
      cyc();
      if (i == 25) chk("freeze_dev", int'(devide), 3);
      ce += int'(enable);
    end
    chk("freeze_len", ce, 32);
    chk("freeze_after", int'(devide), 0);
    // reset aborts a step
    swDevide = 4'd3;
    repeat (10) cyc();
    btnStep = 1'b1;
    n = 0;
    while (enable !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("abort_start", n, 7);
    btnStep = 1'b0;
    repeat (9) cyc();
    do_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    saw = 0;
    repeat (50) begin cyc(); if (enable) saw = 1; end
    chk("abort_no_residual", saw, 0);
    // randomized segments
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 99) < 3) begin
        do_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
      end else begin
        swRun    = ($urandom_range(0, 3) == 0);
        btnStep  = 1'($urandom_range(0, 1));
        swDevide = 4'($urandom_range(0, 3));
        repeat ($urandom_range(1, 12)) cyc();
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
